// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI subordinate.
package spi_pkg;

   localparam int unsigned SPI_WIDTH  = 8;
   localparam logic [7:0]  SPI_DEF_TX = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      RELOAD = 2'd2
   } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus a history flop for single-cycle edge pulses.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sr <= {3{RST_VAL}};
      else        sr <= {sr[1:0], din};
   end

   assign sync = sr[1];
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 subordinate: oversampled SCK/CS_n/MOSI, one-deep tx holding register.
// Optional SPI_SLAVE_MISO_OE_EN adds miso_oe (high while selected) for a shared MISO line.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned      WIDTH  = SPI_WIDTH,
   parameter logic [WIDTH-1:0] DEF_TX = WIDTH'(SPI_DEF_TX)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sck,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
`ifdef SPI_SLAVE_MISO_OE_EN
   output logic             miso_oe,
`endif
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             underrun,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic sck_sync_unused, sck_rise, sck_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic [1:0] mosi_ff;
   logic       mosi_sync;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .reset(reset), .din(sck),
      .sync(sck_sync_unused), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .reset(reset), .din(cs_n),
      .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) mosi_ff <= '0;
      else        mosi_ff <= {mosi_ff[0], mosi};
   end
   assign mosi_sync = mosi_ff[1];

   spi_slv_state_t   state_q, state_d;
   logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] rx_data_d;
   logic             rx_valid_d, underrun_d, tx_ready_d;
   logic             load, accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         tx_sr_q  <= '0;
         rx_sr_q  <= '0;
         cnt_q    <= '0;
         hold_q   <= '0;
         tx_ready <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_sr_q  <= tx_sr_d;
         rx_sr_q  <= rx_sr_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         tx_ready <= tx_ready_d;
         rx_data  <= rx_data_d;
         rx_valid <= rx_valid_d;
         underrun <= underrun_d;
      end
   end

   // Next-state and datapath; a load reads the holding register before any same-cycle accept.
   always_comb begin
      state_d    = state_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      cnt_d      = cnt_q;
      rx_data_d  = rx_data;
      rx_valid_d = 1'b0;
      underrun_d = 1'b0;
      load       = 1'b0;

      if (cs_rise) begin
         state_d = IDLE;
         tx_sr_d = '0;
         rx_sr_d = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  load    = 1'b1;
                  cnt_d   = '0;
                  rx_sr_d = '0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (sck_rise) begin
                  rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_sync};
                  if (cnt_q == LAST_BIT) begin
                     cnt_d      = '0;
                     rx_data_d  = rx_sr_d;
                     rx_valid_d = 1'b1;
                     state_d    = RELOAD;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else if (sck_fall) begin
                  tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
               end
            end
            RELOAD: begin
               if (sck_fall) begin
                  load    = 1'b1;
                  state_d = SHIFT;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (load) begin
         tx_sr_d    = tx_ready ? DEF_TX : hold_q;
         underrun_d = tx_ready;
      end

      accept     = tx_valid & tx_ready;
      hold_d     = accept ? tx_data : hold_q;
      tx_ready_d = accept ? 1'b0 : (load ? 1'b1 : tx_ready);
   end

   assign miso = tx_sr_q[WIDTH-1];
   assign busy = ~cs_sync;
`ifdef SPI_SLAVE_MISO_OE_EN
   assign miso_oe = busy;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave against a byte-level model of the SPI exchange.
module tb_spi_slave;

   localparam logic [7:0] DEF = 8'h00;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sck = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       miso, tx_ready, rx_valid, underrun, busy;
   logic [7:0] rx_data;
`ifdef SPI_SLAVE_MISO_OE_EN
   logic       miso_oe;
`endif

   spi_slave dut (
      .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
`ifdef SPI_SLAVE_MISO_OE_EN
      .miso_oe(miso_oe),
`endif
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: bytes sitting in the holding register, bytes the master has completed.
   logic [7:0] hold_q[$];
   logic [7:0] exp_rx_q[$];
   int         under_cnt = 0;
   int         exp_under = 0;
   logic [7:0] mo[4];
   logic       feed_en[4];
   logic [7:0] feed_val[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Each rx_valid pulse must match the oldest completed byte; underrun pulses are tallied.
   always @(negedge clk) begin : mon
      logic [7:0] e;
      if (reset) begin
         if (underrun) under_cnt++;
         if (rx_valid) begin
            if (exp_rx_q.size() == 0) check("rx_valid_unexpected", 32'(1), 32'(0));
            else begin
               e = exp_rx_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(e));
            end
         end
      end
   end

   task automatic offer(input logic [7:0] d);
      int n = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_ready) break;
         n++;
         if (n > 100) begin
            check("offer_timeout", 32'(0), 32'(1));
            tx_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      hold_q.push_back(d);
   endtask

   // Mode-0 master: n bytes under one CS_n; abort_at>0 raises CS_n after that many rises.
   task automatic xfer(input int n, input int abort_at);
      logic [7:0] e;
      int rises = 0;
      cs_n = 1'b0;
      mosi = mo[0][7];
      for (int b = 0; b < n; b++) begin
         if (hold_q.size() > 0) e = hold_q.pop_front();
         else begin
            e = DEF;
            exp_under++;
         end
         for (int i = 7; i >= 0; i--) begin
            clks(4);
            check("miso_bit", 32'(miso), 32'(e[i]));
            sck = 1'b1;
            rises++;
            if (rises == abort_at) begin
               clks(4);
               cs_n = 1'b1;
               clks(4);
               sck = 1'b0;
               clks(4);
               check("abort_busy", 32'(busy), 32'(0));
               check("abort_miso", 32'(miso), 32'(0));
               return;
            end
            if (i == 0) exp_rx_q.push_back(mo[b]);
            if (i == 5 && feed_en[b]) offer(feed_val[b]);
            clks(4);
            if (b == n - 1 && i == 0) begin
               cs_n = 1'b1;
               clks(4);
               sck = 1'b0;
            end else begin
               sck  = 1'b0;
               mosi = (i > 0) ? mo[b][i-1] : mo[b+1][7];
            end
         end
      end
      clks(6);
      check("end_busy", 32'(busy), 32'(0));
      check("idle_miso", 32'(miso), 32'(0));
      check("rx_pending", 32'(exp_rx_q.size()), 32'(0));
      check("underrun_cnt", 32'(under_cnt), 32'(exp_under));
   endtask

   task automatic no_feed();
      for (int k = 0; k < 4; k++) begin
         feed_en[k]  = 1'b0;
         feed_val[k] = 8'h00;
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int u0;
      no_feed();
      clks(3);
      check("rst_miso", 32'(miso), 32'(0));
      check("rst_tx_ready", 32'(tx_ready), 32'(1));
      check("rst_rx_data", 32'(rx_data), 32'(0));
      check("rst_rx_valid", 32'(rx_valid), 32'(0));
      check("rst_underrun", 32'(underrun), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      reset = 1'b1;
      clks(4);

      // Single byte
      offer(8'hA5);
      check("t1_tx_ready_low", 32'(tx_ready), 32'(0));
      mo[0] = 8'h3C;
      xfer(1, 0);
      check("t1_rx_data", 32'(rx_data), 32'h3C);
      check("t1_underrun", 32'(under_cnt), 32'(0));
      check("t1_tx_ready", 32'(tx_ready), 32'(1));
      clks(8);

      // Burst of two bytes
      offer(8'h11);
      mo[0] = 8'hF0; mo[1] = 8'h0F;
      feed_en[0] = 1'b1; feed_val[0] = 8'h22;
      xfer(2, 0);
      no_feed();
      check("t2_rx_data", 32'(rx_data), 32'h0F);
      check("t2_underrun", 32'(under_cnt), 32'(0));
      clks(8);

      // Underrun
      u0 = under_cnt;
      mo[0] = 8'h55;
      xfer(1, 0);
      check("t3_underrun_once", 32'(under_cnt - u0), 32'(1));
      check("t3_rx_data", 32'(rx_data), 32'h55);
      clks(8);

      // Abort after five rises
      mo[0] = 8'($urandom);
      xfer(1, 5);
      clks(4);
      check("t4_rx_kept", 32'(rx_data), 32'h55);
      check("t4_underrun", 32'(under_cnt), 32'(exp_under));
      mo[0] = 8'hA7;
      xfer(1, 0);
      check("t4_next_rx", 32'(rx_data), 32'hA7);
      clks(8);

      // Asynchronous reset mid-frame
      offer(8'h9A);
      cs_n = 1'b0;
      mosi = 1'b1;
      clks(4);
      repeat (3) begin
         sck = 1'b1; clks(4);
         sck = 1'b0; clks(4);
      end
      reset = 1'b0;
      #1;
      check("t5_miso", 32'(miso), 32'(0));
      check("t5_tx_ready", 32'(tx_ready), 32'(1));
      check("t5_rx_data", 32'(rx_data), 32'(0));
      check("t5_rx_valid", 32'(rx_valid), 32'(0));
      check("t5_underrun", 32'(underrun), 32'(0));
      check("t5_busy", 32'(busy), 32'(0));
      hold_q.delete();
      cs_n = 1'b1;
      sck  = 1'b0;
      clks(2);
      reset = 1'b1;
      clks(4);
      mo[0] = 8'hC3;
      xfer(1, 0);
      check("t5_rx_after", 32'(rx_data), 32'hC3);
      clks(8);

      // SCK toggling while deselected
      repeat (10) begin
         mosi = 1'($urandom);
         sck = 1'b1; clks(3);
         sck = 1'b0; clks(3);
      end
      check("t6_idle_miso", 32'(miso), 32'(0));
      check("t6_idle_busy", 32'(busy), 32'(0));
      mo[0] = 8'h7E;
      xfer(1, 0);
      check("t6_rx_data", 32'(rx_data), 32'h7E);
      clks(8);

      // Randomised frames
      for (int f = 0; f < 20; f++) begin
         int n;
         n = int'($urandom_range(1, 3));
         for (int k = 0; k < 4; k++) begin
            mo[k]       = 8'($urandom);
            feed_en[k]  = 1'($urandom);
            feed_val[k] = 8'($urandom);
         end
         if (hold_q.size() == 0 && ($urandom % 2) == 1) offer(8'($urandom));
         xfer(n, 0);
         clks(int'($urandom_range(4, 10)));
      end
      no_feed();

      clks(10);
      check("final_rx_pending", 32'(exp_rx_q.size()), 32'(0));
      check("final_underrun", 32'(under_cnt), 32'(exp_under));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI subordinate (mode 0, CPOL=0/CPHA=0, MSB first, 8-bit frames); the responder side of the team's spi_master.
- Oversamples SCK/CS_n/MOSI in the local clk domain, deserialises MOSI into rx bytes and serialises queued tx bytes onto MISO.
- Sits between an external SPI bus and on-chip logic.
- Provides a valid/ready tx handshake, a one-cycle rx_valid strobe, and supports multi-byte bursts while CS_n is held low.

Parameters:
- WIDTH, 8, frame length in bits; bit counter is $clog2(WIDTH) wide.
- DEF_TX, 8'h00, byte shifted out when no tx byte is queued (underrun).

Ports:
- clk  in  1  system clock; must be at least 6x SCK frequency.
- reset  in  1  asynchronous, active-low.
- sck  in  1  SPI clock from master; asynchronous to clk.
- cs_n  in  1  chip select, active-low; asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- tx_data  in  WIDTH  byte to send in a later frame.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid and tx_ready are both high.
- rx_data  out  WIDTH  last complete received byte.
- rx_valid  out  1  one-clk strobe: rx_data updated.
- underrun  out  1  one-clk strobe: DEF_TX was loaded instead of a queued byte.
- busy  out  1  synchronised cs_n is low.

Behaviour:
- Reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, busy=0. State=IDLE, both shift registers 0, bit_cnt 0, holding register empty.
- Input synchronisation:
  - sck, cs_n and mosi each pass through a 2-FF synchroniser.
  - A third flop on sck and cs_n provides edge detection: sck_rise, sck_fall, cs_fall, cs_rise (each one clk wide).
- Holding register:
  - Accepts tx_data when tx_valid and tx_ready are both high; tx_ready then drops the next cycle.
  - Freed (tx_ready=1) in the same cycle its contents are loaded into the tx shift register.
- State machine (three states):
  - IDLE: miso=0. On cs_fall, load the tx shift register (holding byte, or DEF_TX with an underrun pulse), clear bit_cnt, go to SHIFT.
  - SHIFT, on sck_rise: rx_sr <= {rx_sr[WIDTH-2:0], mosi_sync}; bit_cnt++.
  - SHIFT, on the WIDTH-th rise: rx_data <= the completed byte and rx_valid pulses the following cycle (latency 1 clk after sck_rise detection); bit_cnt wraps to 0; go to RELOAD.
  - SHIFT, on any other sck_fall: tx_sr shifts left by 1.
  - RELOAD, on sck_fall: load the next tx byte (or DEF_TX with underrun) and return to SHIFT. This supports back-to-back bytes within one CS_n assertion.
  - Any state, on cs_rise: return to IDLE. A partial rx byte is discarded (no rx_valid). The tx byte in flight is lost; the holding register is untouched.
- miso = tx_sr[WIDTH-1], combinational from the register, valid within 4 clk of cs_fall or sck_fall.
- Simultaneous holding-register accept and load in the same cycle: the load takes the old contents (or DEF_TX if empty); the accepted byte is written afterwards, so there is no bypass.
- Asynchronous reset mid-frame: everything returns to reset values immediately; the frame is abandoned.
- cs_n held low with no SCK activity: the block stays in SHIFT indefinitely with no timeout.
- SCK edges while cs_n is high (synchronised) are ignored.

Optional Feature:
- Macro SPI_SLAVE_MISO_OE_EN.
- Defined: adds output port miso_oe (1 bit), high iff busy. This allows an external tri-state buffer on a shared MISO line; miso itself is unchanged.
- Undefined: no miso_oe port; miso is driven 0 whenever the block is in IDLE.

Decomposition:
- Package spi_pkg:
  - typedef enum logic [1:0] spi_slv_state_t {IDLE, SHIFT, RELOAD}.
  - localparam SPI_WIDTH = 8.
  - localparam SPI_DEF_TX = 8'h00.
- Sub-module spi_sync_edge: 2-FF synchroniser plus previous-value flop, outputs sync/rise/fall. Instantiated for sck and cs_n; mosi uses a synchroniser only.

Test Plan:
- Single byte: load tx 8'hA5, master sends 8'h3C (SCK = clk/8) -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; one rx_valid pulse; underrun=0.
- Burst: queue 8'h11, then 8'h22 when tx_ready rises; master sends 8'hF0, 8'h0F under one CS_n -> MISO returns 11,22; two rx_valid pulses with 8'hF0 then 8'h0F.
- Underrun: no tx queued, DEF_TX=8'h00, master sends 8'h55 -> MISO all 0; underrun pulses once at cs_fall; rx_data=8'h55.
- Abort: CS_n rises after 5 SCK rises -> no rx_valid, rx_data keeps its previous value, busy falls, state IDLE; next full frame is received correctly.
- Async reset asserted mid-frame after 3 bits -> all outputs return to reset values immediately, tx_ready=1; a following 8'hC3 frame is received intact.
- SCK toggling with CS_n high, then a normal frame of 8'h7E -> no rx_valid from the idle toggles; the normal frame gives rx_data=8'h7E.
